// File: rtl/pwm_multi.sv
// pwm_multi -- multi-channel PWM generator sharing one period counter.
//
// Ports:
//   fclk         system clock
//   reset        asynchronous, active-low reset
//   wr_en        register write strobe (one write per asserted cycle)
//   wr_addr      register address
//   wr_data      write data
//   oPWM         PWM outputs, one per channel, registered
//   period_done  one-cycle pulse after each completed period, registered
//
// Register map: 0..CHANNELS-1 staging duty, CHANNELS staging period,
// CHANNELS+1 ctrl (bit0 en, bit1 mode), CHANNELS+2 polarity mask.
// Duty, period and mode are double-buffered; the active copies load from
// staging on the period boundary so a period never changes shape midway.
module pwm_multi #(
    parameter int          CHANNELS   = 4,
    parameter int          CNT_W      = 20,
    parameter int          ADDR_W     = 3,
    parameter int unsigned DEF_PERIOD = 1000000
) (
    input  logic                fclk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [CNT_W-1:0]    wr_data,
    output logic [CHANNELS-1:0] oPWM,
    output logic                period_done
);

    localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(CHANNELS);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(CHANNELS + 1);
    localparam logic [ADDR_W-1:0] ADDR_POL    = ADDR_W'(CHANNELS + 2);
    localparam logic [CNT_W-1:0]  PERIOD_RST  = CNT_W'(DEF_PERIOD);

    logic                en_reg;
    logic                mode_stage_reg;
    logic                mode_stage_next;
    logic                mode_act_reg;
    logic [CHANNELS-1:0] pol_reg;
    logic [CNT_W-1:0]    period_stage_reg;
    logic [CNT_W-1:0]    period_stage_next;
    logic [CNT_W-1:0]    period_act_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic                down_reg;
    logic                down_next;
    logic                boundary;
    logic                halted;
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] pwm_reg;
    logic                done_reg;

    assign halted = !en_reg || (period_act_reg < CNT_W'(2));

    // Staging values including any write landing on this edge. While halted
    // the active copies follow these, so re-enabling always starts from the
    // latest programmed values (including a mode set in the same ctrl write).
    always_comb begin
        period_stage_next = period_stage_reg;
        mode_stage_next   = mode_stage_reg;
        if (wr_en && wr_addr == ADDR_PERIOD) begin
            period_stage_next = wr_data;
        end
        if (wr_en && wr_addr == ADDR_CTRL) begin
            mode_stage_next = wr_data[1];
        end
    end

    // Counter sequencing. Edge mode: 0..P-1 then wrap. Center mode: up to P,
    // down to 1, then back to 0; the boundary is the final 1->0 step.
    always_comb begin
        cnt_next  = cnt_reg;
        down_next = down_reg;
        boundary  = 1'b0;
        if (halted) begin
            cnt_next  = '0;
            down_next = 1'b0;
        end else if (!mode_act_reg) begin
            if (cnt_reg == period_act_reg - 1'b1) begin
                cnt_next = '0;
                boundary = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else if (!down_reg) begin
            if (cnt_reg == period_act_reg) begin
                cnt_next  = cnt_reg - 1'b1;
                down_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else begin
            if (cnt_reg == CNT_W'(1)) begin
                cnt_next  = '0;
                down_next = 1'b0;
                boundary  = 1'b1;
            end else begin
                cnt_next = cnt_reg - 1'b1;
            end
        end
    end

    // Per-channel duty registers and raw compare.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [CNT_W-1:0] duty_stage_reg;
            logic [CNT_W-1:0] duty_stage_next;
            logic [CNT_W-1:0] duty_act_reg;

            always_comb begin
                duty_stage_next = duty_stage_reg;
                if (wr_en && wr_addr == ADDR_W'(gi)) begin
                    duty_stage_next = wr_data;
                end
            end

            always_ff @(posedge fclk or negedge reset) begin
                if (!reset) begin
                    duty_stage_reg <= '0;
                    duty_act_reg   <= '0;
                end else begin
                    duty_stage_reg <= duty_stage_next;
                    if (halted) begin
                        duty_act_reg <= duty_stage_next;
                    end else if (boundary) begin
                        // Pre-write staging: a write on the boundary edge
                        // waits for the following boundary.
                        duty_act_reg <= duty_stage_reg;
                    end
                end
            end

            assign raw[gi] = (cnt_reg < duty_act_reg);
        end
    endgenerate

    always_ff @(posedge fclk or negedge reset) begin
        if (!reset) begin
            en_reg           <= 1'b0;
            mode_stage_reg   <= 1'b0;
            mode_act_reg     <= 1'b0;
            pol_reg          <= '0;
            period_stage_reg <= PERIOD_RST;
            period_act_reg   <= PERIOD_RST;
            cnt_reg          <= '0;
            down_reg         <= 1'b0;
            pwm_reg          <= '0;
            done_reg         <= 1'b0;
        end else begin
            if (wr_en && wr_addr == ADDR_CTRL) begin
                en_reg <= wr_data[0];
            end
            if (wr_en && wr_addr == ADDR_POL) begin
                pol_reg <= wr_data[CHANNELS-1:0];
            end
            mode_stage_reg   <= mode_stage_next;
            period_stage_reg <= period_stage_next;
            if (halted) begin
                mode_act_reg   <= mode_stage_next;
                period_act_reg <= period_stage_next;
            end else if (boundary) begin
                mode_act_reg   <= mode_stage_reg;
                period_act_reg <= period_stage_reg;
            end
            cnt_reg  <= cnt_next;
            down_reg <= down_next;
            pwm_reg  <= halted ? pol_reg : (raw ^ pol_reg);
            done_reg <= boundary;
        end
    end

    assign oPWM        = pwm_reg;
    assign period_done = done_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi (4 channels, 20-bit counter, 3-bit address).
module tb_pwm_multi;

    logic        fclk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [19:0] wr_data;
    logic [3:0]  oPWM;
    logic        period_done;

    int errors = 0;
    int checks = 0;

    pwm_multi #(
        .CHANNELS   (4),
        .CNT_W      (20),
        .ADDR_W     (3),
        .DEF_PERIOD (1000000)
    ) dut (
        .fclk        (fclk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .oPWM        (oPWM),
        .period_done (period_done)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic do_write(input logic [2:0] a, input logic [19:0] d);
        @(negedge fclk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge fclk);
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        $display("write addr=%0d data=%0d", a, d);
    endtask

    task automatic apply_reset();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        reset   = 1'b0;
        repeat (2) @(negedge fclk);
        reset = 1'b1;
    endtask

    // Waits (at negedges) for a period_done pulse, bounded by limit cycles.
    task automatic wait_done(input int limit, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge fclk);
            if (period_done === 1'b1) begin
                ok = 1'b1;
                cycles = i;
                return;
            end
        end
    endtask

    // Samples n negedges starting with the current one.
    task automatic window(input int n,
                          output logic [31:0] p0, output logic [31:0] p1,
                          output logic [31:0] p2, output logic [31:0] p3,
                          output logic [31:0] pd,
                          output int c0, output int c1, output int c2,
                          output int c3, output int cd);
        p0 = '0; p1 = '0; p2 = '0; p3 = '0; pd = '0;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; cd = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge fclk);
            if (k < 32) begin
                p0[k] = oPWM[0];
                p1[k] = oPWM[1];
                p2[k] = oPWM[2];
                p3[k] = oPWM[3];
                pd[k] = period_done;
            end
            c0 += (oPWM[0] === 1'b1) ? 1 : 0;
            c1 += (oPWM[1] === 1'b1) ? 1 : 0;
            c2 += (oPWM[2] === 1'b1) ? 1 : 0;
            c3 += (oPWM[3] === 1'b1) ? 1 : 0;
            cd += (period_done === 1'b1) ? 1 : 0;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(negedge fclk);
        checks++;
        if (oPWM !== 4'h0 || period_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: oPWM=%h done=%b expected oPWM=0 done=0", oPWM, period_done);
        end
        reset = 1'b1;
        repeat (3) @(negedge fclk);
        checks++;
        if (oPWM !== 4'h0 || period_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_halted: oPWM=%h done=%b expected oPWM=0 done=0", oPWM, period_done);
        end
        $display("test_reset done");
    endtask

    task automatic test_edge_basic();
        bit ok;
        int cyc;
        logic [31:0] p0, p1, p2, p3, pd;
        int c0, c1, c2, c3, cd;
        apply_reset();
        do_write(3'd0, 20'd3);
        do_write(3'd1, 20'd0);
        do_write(3'd2, 20'd10);
        do_write(3'd3, 20'd15);
        do_write(3'd4, 20'd10);
        do_write(3'd5, 20'd1);
        @(negedge fclk);
        checks++;
        if (oPWM !== 4'hD) begin
            errors++;
            $display("FAIL edge_first_compare: oPWM=%h expected d", oPWM);
        end
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || cyc != 9) begin
            errors++;
            $display("FAIL edge_first_done: ok=%0d cycles=%0d expected ok=1 cycles=9", ok, cyc);
        end
        window(30, p0, p1, p2, p3, pd, c0, c1, c2, c3, cd);
        $display("edge window ch0=%h done=%h counts %0d %0d %0d %0d %0d", p0, pd, c0, c1, c2, c3, cd);
        checks++;
        if (p0 !== 32'h00E0380E) begin
            errors++;
            $display("FAIL edge_ch0_pattern: got %h expected 00e0380e", p0);
        end
        checks++;
        if (pd !== 32'h00100401) begin
            errors++;
            $display("FAIL edge_done_pattern: got %h expected 00100401", pd);
        end
        checks++;
        if (c1 != 0 || c2 != 30 || c3 != 30) begin
            errors++;
            $display("FAIL edge_ch123_counts: got %0d %0d %0d expected 0 30 30", c1, c2, c3);
        end
    endtask

    task automatic test_shadow();
        bit ok;
        int cyc;
        logic [31:0] p, d;
        wait_done(12, ok, cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL shadow_sync1: no period_done within 12 cycles, expected one");
        end
        p = '0;
        d = '0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge fclk);
            p[k] = oPWM[0];
            d[k] = period_done;
            if (k == 0) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_data = 20'd7;
            end
            if (k == 1) begin
                wr_en = 1'b0; wr_addr = '0; wr_data = '0;
            end
        end
        $display("shadow midperiod ch0=%h done=%h", p, d);
        checks++;
        if (p !== 32'h0003F80E || d !== 32'h00000401) begin
            errors++;
            $display("FAIL shadow_midperiod: ch0=%h done=%h expected 0003f80e 00000401", p, d);
        end
        wait_done(12, ok, cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL shadow_sync2: no period_done within 12 cycles, expected one");
        end
        p = '0;
        d = '0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge fclk);
            p[k] = oPWM[0];
            d[k] = period_done;
            if (k == 9) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_data = 20'd2;
            end
            if (k == 10) begin
                wr_en = 1'b0; wr_addr = '0; wr_data = '0;
            end
        end
        $display("shadow boundary ch0=%h done=%h", p, d);
        checks++;
        if (p !== 32'h0063F8FE || d !== 32'h00100401) begin
            errors++;
            $display("FAIL shadow_boundary: ch0=%h done=%h expected 0063f8fe 00100401", p, d);
        end
    endtask

    task automatic test_center();
        bit ok;
        int cyc;
        logic [31:0] p0, p1, p2, p3, pd;
        int c0, c1, c2, c3, cd;
        apply_reset();
        do_write(3'd4, 20'd8);
        do_write(3'd0, 20'd4);
        do_write(3'd5, 20'd3);
        wait_done(40, ok, cyc);
        checks++;
        if (!ok || cyc != 16) begin
            errors++;
            $display("FAIL center_first_done: ok=%0d cycles=%0d expected ok=1 cycles=16", ok, cyc);
        end
        window(32, p0, p1, p2, p3, pd, c0, c1, c2, c3, cd);
        $display("center window ch0=%h done=%h count=%0d", p0, pd, c0);
        checks++;
        if (p0 !== 32'hC01FC01F) begin
            errors++;
            $display("FAIL center_ch0_pattern: got %h expected c01fc01f", p0);
        end
        checks++;
        if (pd !== 32'h00010001) begin
            errors++;
            $display("FAIL center_done_pattern: got %h expected 00010001", pd);
        end
    endtask

    task automatic test_polarity_halt();
        bit ok;
        int cyc;
        int bad;
        logic [31:0] p0, p1, p2, p3, pd;
        int c0, c1, c2, c3, cd;
        apply_reset();
        do_write(3'd6, 20'h5);
        do_write(3'd0, 20'd3);
        checks++;
        if (oPWM !== 4'h5 || period_done !== 1'b0) begin
            errors++;
            $display("FAIL pol_disabled: oPWM=%h done=%b expected 5 0", oPWM, period_done);
        end
        do_write(3'd4, 20'd1);
        do_write(3'd5, 20'd1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge fclk);
            if (oPWM !== 4'h5 || period_done !== 1'b0) bad++;
        end
        $display("halt P=1 bad samples=%0d", bad);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_p1: bad samples=%0d expected 0", bad);
        end
        do_write(3'd4, 20'd10);
        wait_done(12, ok, cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL halt_resume: no period_done within 12 cycles, expected one");
        end
        window(10, p0, p1, p2, p3, pd, c0, c1, c2, c3, cd);
        $display("pol window counts %0d %0d %0d %0d done %0d", c0, c1, c2, c3, cd);
        checks++;
        if (c0 != 7 || c1 != 0 || c2 != 10 || c3 != 0 || cd != 1) begin
            errors++;
            $display("FAIL pol_running: counts %0d %0d %0d %0d done %0d expected 7 0 10 0 1",
                     c0, c1, c2, c3, cd);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int cyc;
        logic [31:0] p0, p1, p2, p3, pd;
        int c0, c1, c2, c3, cd;
        apply_reset();
        do_write(3'd4, 20'd10);
        do_write(3'd0, 20'd15);
        do_write(3'd1, 20'd5);
        do_write(3'd5, 20'd1);
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || oPWM[0] !== 1'b1) begin
            errors++;
            $display("FAIL areset_prep: ok=%0d ch0=%b expected 1 1", ok, oPWM[0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (oPWM !== 4'h0 || period_done !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: oPWM=%h done=%b expected 0 0", oPWM, period_done);
        end
        repeat (2) @(negedge fclk);
        reset = 1'b1;
        @(negedge fclk);
        window(5, p0, p1, p2, p3, pd, c0, c1, c2, c3, cd);
        checks++;
        if (c0 + c1 + c2 + c3 + cd != 0) begin
            errors++;
            $display("FAIL areset_halted: high samples=%0d expected 0", c0 + c1 + c2 + c3 + cd);
        end
        do_write(3'd0, 20'd20);
        do_write(3'd5, 20'd1);
        @(negedge fclk);
        window(100, p0, p1, p2, p3, pd, c0, c1, c2, c3, cd);
        $display("after reset ch0=%h count=%0d done=%0d", p0, c0, cd);
        checks++;
        if (p0 !== 32'h000FFFFF || c0 != 20 || cd != 0) begin
            errors++;
            $display("FAIL areset_def_period: ch0=%h count=%0d done=%0d expected 000fffff 20 0",
                     p0, c0, cd);
        end
    endtask

    task automatic test_invalid_addr();
        bit ok;
        int cyc;
        logic [31:0] p0, p1, p2, p3, pd;
        int c0, c1, c2, c3, cd;
        apply_reset();
        do_write(3'd4, 20'd10);
        do_write(3'd0, 20'd3);
        do_write(3'd5, 20'd1);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) do_write(3'd7, 20'hFFFFF);
            wait_done(20, ok, cyc);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL invalid_sync%0d: no period_done within 20 cycles, expected one", pass);
            end
            window(20, p0, p1, p2, p3, pd, c0, c1, c2, c3, cd);
            $display("invalid pass %0d ch0=%h done=%h", pass, p0, pd);
            checks++;
            if (p0 !== 32'h0000380E || pd !== 32'h00000401 || (p1 | p2 | p3) !== 32'h0) begin
                errors++;
                $display("FAIL invalid_pass%0d: ch0=%h done=%h other=%h expected 0000380e 00000401 0",
                         pass, p0, pd, p1 | p2 | p3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_shadow();
        test_center();
        test_polarity_halt();
        test_async_reset();
        test_invalid_addr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
